// File: rtl/paddle_pkg.sv
// Shared constants for the paddle controller: screen size, default geometry,
// colour table and the per-paddle direction encoding.
package paddle_pkg;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int DEF_PADDLE_H = 50;
  localparam int DEF_PADDLE_W = 10;
  localparam int DEF_MARGIN   = 30;
  localparam int DEF_SPEED    = 4;
  localparam int COORD_W      = 10;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // {r,g,b} per paddle, paddle k at bits [3k+2:3k]: white, cyan, yellow, magenta
  localparam logic [11:0] COLOUR_TABLE = {3'b101, 3'b110, 3'b011, 3'b111};

  function automatic int paddle_x(input int k, input int n, input int margin,
                                  input int sw, input int pw);
    if (n <= 1) return margin;
    return margin + k * (sw - 2 * margin - pw) / (n - 1);
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// One paddle's vertical position register with saturating moves; with
// PADDLE_CTRL_ACCEL_EN a 3-bit hold counter doubles the step after long presses.
module paddle_axis
  import paddle_pkg::*;
#(
  parameter int SPEED = DEF_SPEED,
  parameter int YMAX  = SCREEN_H - DEF_PADDLE_H,
  parameter int YRST  = (SCREEN_H - DEF_PADDLE_H) / 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_up,
  input  logic       i_down,
  output logic [9:0] o_y
);

  localparam logic [10:0] YMAX_11 = 11'(YMAX);
  localparam logic [10:0] STEP_1  = 11'(SPEED);
  localparam logic [10:0] STEP_2  = 11'(2 * SPEED);
  localparam logic [9:0]  Y_RST   = 10'(YRST);

  dir_e        dir;
  logic [10:0] step;
  logic [10:0] diff;
  logic [10:0] sum;
  logic [9:0]  y_q, y_d;

  always_comb begin
    dir = DIR_IDLE;
    if (i_up && !i_down)      dir = DIR_UP;
    else if (i_down && !i_up) dir = DIR_DOWN;
  end

`ifdef PADDLE_CTRL_ACCEL_EN
  logic [2:0] hold_q, hold_d;
  dir_e       last_dir_q, last_dir_d;

  always_comb begin
    hold_d     = hold_q;
    last_dir_d = last_dir_q;
    if (i_tick) begin
      last_dir_d = dir;
      if (dir != DIR_IDLE && dir == last_dir_q)
        hold_d = (hold_q == 3'd7) ? 3'd7 : hold_q + 3'd1;
      else
        hold_d = 3'd0;
    end
  end

  // the tick that brings the counter to 7 already uses the fast step
  assign step = (hold_d == 3'd7) ? STEP_2 : STEP_1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q     <= 3'd0;
      last_dir_q <= DIR_IDLE;
    end else begin
      hold_q     <= hold_d;
      last_dir_q <= last_dir_d;
    end
  end
`else
  assign step = STEP_1;
`endif

  // 11-bit arithmetic: a borrow shows up in bit 10, overshoot is caught against YMAX
  always_comb begin
    diff = {1'b0, y_q} - step;
    sum  = {1'b0, y_q} + step;
    y_d  = y_q;
    if (i_tick) begin
      case (dir)
        DIR_UP:   y_d = diff[10] ? 10'd0 : diff[9:0];
        DIR_DOWN: y_d = (sum > YMAX_11) ? YMAX_11[9:0] : sum[9:0];
        default:  y_d = y_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) y_q <= Y_RST;
    else          y_q <= y_d;
  end

  assign o_y = y_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Multi-paddle controller: per-paddle position registers plus a registered
// hit/colour renderer. Define PADDLE_CTRL_ACCEL_EN for held-key acceleration.
module paddle_ctrl
  import paddle_pkg::*;
#(
  parameter int NUM_PADDLES   = 2,
  parameter int PADDLE_HEIGHT = DEF_PADDLE_H,
  parameter int PADDLE_WIDTH  = DEF_PADDLE_W,
  parameter int PADDLE_MARGIN = DEF_MARGIN,
  parameter int SCREEN_WIDTH  = SCREEN_W,
  parameter int SCREEN_HEIGHT = SCREEN_H,
  parameter int SPEED         = DEF_SPEED
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_frame_tick,
  input  logic [NUM_PADDLES-1:0]    i_up,
  input  logic [NUM_PADDLES-1:0]    i_down,
  input  logic [9:0]                i_pixel_x,
  input  logic [9:0]                i_pixel_y,
  input  logic                      i_visible,
  output logic [10*NUM_PADDLES-1:0] o_paddle_y,
  output logic [NUM_PADDLES-1:0]    o_hit,
  output logic                      o_r,
  output logic                      o_g,
  output logic                      o_b
);

  localparam int YMAX = SCREEN_HEIGHT - PADDLE_HEIGHT;
  localparam int YRST = YMAX / 2;

  logic [NUM_PADDLES-1:0] hit_d, hit_q;
  logic [2:0]             rgb_d, rgb_q;
  logic [10:0]            px_11, py_11;

  assign px_11 = {1'b0, i_pixel_x};
  assign py_11 = {1'b0, i_pixel_y};

  for (genvar k = 0; k < NUM_PADDLES; k++) begin : g_paddle
    localparam int          XK   = paddle_x(k, NUM_PADDLES, PADDLE_MARGIN,
                                            SCREEN_WIDTH, PADDLE_WIDTH);
    localparam logic [10:0] X_LO = 11'(XK);
    localparam logic [10:0] X_HI = 11'(XK + PADDLE_WIDTH);

    logic [9:0]  y;
    logic [10:0] y_lo, y_hi;

    paddle_axis #(
      .SPEED (SPEED),
      .YMAX  (YMAX),
      .YRST  (YRST)
    ) u_axis (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_tick  (i_frame_tick),
      .i_up    (i_up[k]),
      .i_down  (i_down[k]),
      .o_y     (y)
    );

    assign o_paddle_y[10*k +: 10] = y;
    assign y_lo     = {1'b0, y};
    assign y_hi     = y_lo + 11'(PADDLE_HEIGHT);
    // uses the y held this cycle, so a coincident tick only affects later pixels
    assign hit_d[k] = i_visible && (px_11 >= X_LO) && (px_11 < X_HI) &&
                      (py_11 >= y_lo) && (py_11 < y_hi);
  end

  always_comb begin
    rgb_d = 3'b000;
    for (int k = NUM_PADDLES - 1; k >= 0; k--) begin
      if (hit_d[k]) rgb_d = COLOUR_TABLE[3*k +: 3];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_q <= '0;
      rgb_q <= 3'b000;
    end else begin
      hit_q <= hit_d;
      rgb_q <= rgb_d;
    end
  end

  assign o_hit = hit_q;
  assign o_r   = rgb_q[2];
  assign o_g   = rgb_q[1];
  assign o_b   = rgb_q[0];

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl at default parameters; the acceleration
// scenario runs only when PADDLE_CTRL_ACCEL_EN is defined.
module tb_paddle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [1:0]  up = 2'b00;
  logic [1:0]  down = 2'b00;
  logic [9:0]  px = 10'd0;
  logic [9:0]  py = 10'd0;
  logic        vis = 1'b0;
  logic [19:0] paddle_y;
  logic [1:0]  hit;
  logic        r, g, b;

  int errors = 0;
  int checks = 0;

  int ym[2];
  int hold_cnt[2];
  int last_dir[2];

  typedef struct {
    logic [1:0] hit;
    logic [2:0] rgb;
    int         idx;
  } exp_t;
  exp_t sb[$];

  paddle_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_tick (tick),
    .i_up         (up),
    .i_down       (down),
    .i_pixel_x    (px),
    .i_pixel_y    (py),
    .i_visible    (vis),
    .o_paddle_y   (paddle_y),
    .o_hit        (hit),
    .o_r          (r),
    .o_g          (g),
    .o_b          (b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ym[k]       = 215;
      hold_cnt[k] = 0;
      last_dir[k] = 0;
    end
  endtask

  task automatic model_tick(input logic [1:0] u, input logic [1:0] d);
    for (int k = 0; k < 2; k++) begin
      int dir;
      int step;
      dir  = (u[k] && !d[k]) ? 1 : ((d[k] && !u[k]) ? 2 : 0);
      step = 4;
`ifdef PADDLE_CTRL_ACCEL_EN
      if (dir != 0 && dir == last_dir[k]) hold_cnt[k] = (hold_cnt[k] < 7) ? hold_cnt[k] + 1 : 7;
      else hold_cnt[k] = 0;
      last_dir[k] = dir;
      if (hold_cnt[k] == 7) step = 8;
`endif
      if (dir == 1) ym[k] = (ym[k] - step < 0) ? 0 : ym[k] - step;
      if (dir == 2) ym[k] = (ym[k] + step > 430) ? 430 : ym[k] + step;
    end
  endtask

  task automatic do_tick(input logic [1:0] u, input logic [1:0] d);
    @(negedge clk);
    tick = 1'b1; up = u; down = d;
    model_tick(u, d);
    @(negedge clk);
    tick = 1'b0; up = 2'b00; down = 2'b00;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [4:0] exp_pix(input int x, input int y, input bit v);
    logic h0, h1;
    logic [2:0] rgb;
    h0  = v && x >= 30  && x < 40  && y >= ym[0] && y < ym[0] + 50;
    h1  = v && x >= 600 && x < 610 && y >= ym[1] && y < ym[1] + 50;
    rgb = h0 ? 3'b111 : (h1 ? 3'b011 : 3'b000);
    return {h1, h0, rgb};
  endfunction

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    vis = 1'b1; px = 10'd30; py = 10'd215;
    #12;
    checks++;
    if (paddle_y !== {10'd215, 10'd215}) begin
      errors++; $display("FAIL reset_y_held: got %h want %h", paddle_y, {10'd215, 10'd215});
    end
    checks++;
    if ({hit, r, g, b} !== 5'b0) begin
      errors++; $display("FAIL reset_outs_held: got %b want 00000", {hit, r, g, b});
    end
    vis = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (paddle_y !== {10'd215, 10'd215}) begin
      errors++; $display("FAIL reset_release_y: got %h want %h", paddle_y, {10'd215, 10'd215});
    end
    checks++;
    if ({hit, r, g, b} !== 5'b0) begin
      errors++; $display("FAIL reset_release_outs: got %b want 00000", {hit, r, g, b});
    end
  endtask

  task automatic test_up_saturate();
    for (int t = 1; t <= 60; t++) begin
      do_tick(2'b01, 2'b00);
      checks++;
      if (paddle_y[9:0] !== 10'(ym[0])) begin
        errors++; $display("FAIL up_y0 tick %0d: got %0d want %0d", t, paddle_y[9:0], ym[0]);
      end
      if (t == 53 || t == 54) begin
        checks++;
        if (paddle_y[9:0] !== ((t == 53) ? 10'd3 : 10'd0)) begin
          errors++; $display("FAIL up_floor tick %0d: got %0d", t, paddle_y[9:0]);
        end
      end
    end
    checks++;
    if (paddle_y !== {10'd215, 10'd0}) begin
      errors++; $display("FAIL up_final: got y1=%0d y0=%0d want 215 0", paddle_y[19:10], paddle_y[9:0]);
    end
  endtask

  task automatic test_down_saturate();
    for (int t = 1; t <= 70; t++) begin
      do_tick(2'b00, 2'b10);
      checks++;
      if (paddle_y[19:10] !== 10'(ym[1])) begin
        errors++; $display("FAIL down_y1 tick %0d: got %0d want %0d", t, paddle_y[19:10], ym[1]);
      end
    end
    checks++;
    if (paddle_y[19:10] !== 10'd430) begin
      errors++; $display("FAIL down_ceiling: got %0d want 430", paddle_y[19:10]);
    end
    for (int t = 0; t < 4; t++) begin
      do_tick(2'b11, 2'b11);
      checks++;
      if (paddle_y !== {10'd430, 10'd0}) begin
        errors++; $display("FAIL both_hold: got y1=%0d y0=%0d want 430 0", paddle_y[19:10], paddle_y[9:0]);
      end
    end
    @(negedge clk);
    up = 2'b10; down = 2'b01;
    repeat (2) @(negedge clk);
    up = 2'b00; down = 2'b00;
    checks++;
    if (paddle_y !== {10'd430, 10'd0}) begin
      errors++; $display("FAIL no_tick_hold: got y1=%0d y0=%0d want 430 0", paddle_y[19:10], paddle_y[9:0]);
    end
  endtask

  task automatic test_render();
    int xs[10] = '{30, 29, 40, 30, 600, 39, 30, 609, 610, 30};
    int ys[10] = '{215, 215, 215, 265, 215, 264, 214, 240, 240, 215};
    bit vs[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    exp_t e;
    apply_reset();
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({hit, r, g, b} !== {e.hit, e.rgb}) begin
          errors++; $display("FAIL pixel %0d: got hit=%b rgb=%b want hit=%b rgb=%b", e.idx, hit, {r, g, b}, e.hit, e.rgb);
        end
      end
      if (i < 10) begin
        px = 10'(xs[i]); py = 10'(ys[i]); vis = vs[i];
        e.hit = exp_pix(xs[i], ys[i], vs[i]) >> 3;
        e.rgb = exp_pix(xs[i], ys[i], vs[i]);
        e.idx = i;
        sb.push_back(e);
      end
    end
    // tick coincident with a pixel: the old y decides that pixel
    @(negedge clk);
    px = 10'd30; py = 10'd264; vis = 1'b1;
    tick = 1'b1; up = 2'b01;
    e.hit = exp_pix(30, 264, 1) >> 3; e.rgb = exp_pix(30, 264, 1); e.idx = 100;
    sb.push_back(e);
    model_tick(2'b01, 2'b00);
    @(negedge clk);
    tick = 1'b0; up = 2'b00;
    e = sb.pop_front();
    checks++;
    if ({hit, r, g, b} !== {e.hit, e.rgb} || e.hit !== 2'b01) begin
      errors++; $display("FAIL coincident_old_y: got hit=%b rgb=%b want hit=%b rgb=%b", hit, {r, g, b}, e.hit, e.rgb);
    end
    e.hit = exp_pix(30, 264, 1) >> 3; e.rgb = exp_pix(30, 264, 1); e.idx = 101;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({hit, r, g, b} !== {e.hit, e.rgb} || e.hit !== 2'b00) begin
      errors++; $display("FAIL coincident_new_y: got hit=%b rgb=%b want hit=%b rgb=%b", hit, {r, g, b}, e.hit, e.rgb);
    end
    checks++;
    if (paddle_y[9:0] !== 10'(ym[0])) begin
      errors++; $display("FAIL coincident_y0: got %0d want %0d", paddle_y[9:0], ym[0]);
    end
    vis = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (3) do_tick(2'b01, 2'b10);
    vis = 1'b1; px = 10'd30; py = 10'd215;
    @(negedge clk);
    checks++;
    if (paddle_y !== {10'(ym[1]), 10'(ym[0])} || hit !== 2'b01) begin
      errors++; $display("FAIL pre_reset_state: got y=%h hit=%b want y1=%0d y0=%0d hit=01", paddle_y, hit, ym[1], ym[0]);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (paddle_y !== {10'd215, 10'd215}) begin
      errors++; $display("FAIL async_reset_y: got %h want %h", paddle_y, {10'd215, 10'd215});
    end
    checks++;
    if ({hit, r, g, b} !== 5'b0) begin
      errors++; $display("FAIL async_reset_outs: got %b want 00000", {hit, r, g, b});
    end
    vis = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_tick(2'b01, 2'b00);
    checks++;
    if (paddle_y !== {10'd215, 10'd211}) begin
      errors++; $display("FAIL post_reset_move: got y1=%0d y0=%0d want 215 211", paddle_y[19:10], paddle_y[9:0]);
    end
  endtask

`ifdef PADDLE_CTRL_ACCEL_EN
  task automatic test_accel();
    int prev;
    apply_reset();
    repeat (40) do_tick(2'b01, 2'b00);
    do_tick(2'b00, 2'b00);
    checks++;
    if (paddle_y[9:0] !== 10'd0) begin
      errors++; $display("FAIL accel_start: got %0d want 0", paddle_y[9:0]);
    end
    for (int t = 1; t <= 12; t++) begin
      prev = int'(paddle_y[9:0]);
      do_tick(2'b00, 2'b01);
      checks++;
      if (int'(paddle_y[9:0]) - prev !== ((t <= 7) ? 4 : 8) || paddle_y[9:0] !== 10'(ym[0])) begin
        errors++; $display("FAIL accel_step tick %0d: got step %0d want %0d", t, int'(paddle_y[9:0]) - prev, (t <= 7) ? 4 : 8);
      end
    end
    prev = int'(paddle_y[9:0]);
    do_tick(2'b01, 2'b00);
    checks++;
    if (prev - int'(paddle_y[9:0]) !== 4) begin
      errors++; $display("FAIL accel_reverse: got step %0d want 4", prev - int'(paddle_y[9:0]));
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_up_saturate();
    test_down_saturate();
    test_render();
    test_async_reset();
`ifdef PADDLE_CTRL_ACCEL_EN
    test_accel();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PADDLES, default 2, meaning the number of paddles (legal 1..4).
REQ-002 The block SHALL have parameter PADDLE_HEIGHT, default 50, meaning paddle height in pixels.
REQ-003 The block SHALL have parameter PADDLE_WIDTH, default 10, meaning paddle width in pixels.
REQ-004 The block SHALL have parameter PADDLE_MARGIN, default 30, meaning the gap in pixels from the screen edge to the outer paddle.
REQ-005 The block SHALL have parameter SCREEN_WIDTH, default 640, and parameter SCREEN_HEIGHT, default 480.
REQ-006 The block SHALL have parameter SPEED, default 4, meaning the pixels moved per frame.
REQ-007 i_clk  in  1  the single clock; all state is on its rising edge.
REQ-008 i_rst_n  in  1  asynchronous, active-low reset.
REQ-009 i_frame_tick  in  1  one-cycle pulse per frame, asserted outside the visible area.
REQ-010 i_up, i_down  in  NUM_PADDLES  per-paddle move requests, sampled on i_frame_tick.
REQ-011 i_pixel_x, i_pixel_y  in  10  the current pixel coordinate.
REQ-012 i_visible  in  1  visible-area flag.
REQ-013 o_paddle_y  out  10*NUM_PADDLES  paddle top rows, with paddle k in bits [10k+9:10k].
REQ-014 o_hit  out  NUM_PADDLES  registered flag: the pixel lies inside paddle k.
REQ-015 o_r, o_g, o_b  out  1  registered pixel colour.

Function
REQ-016 Each paddle SHALL hold its top row y in a 10-bit register, with legal range 0..YMAX, where YMAX = SCREEN_HEIGHT-PADDLE_HEIGHT.
REQ-017 On a cycle with i_frame_tick=1 and only i_up[k] asserted, y[k] SHALL become y[k]-SPEED, saturating at 0.
REQ-018 On a cycle with i_frame_tick=1 and only i_down[k] asserted, y[k] SHALL become y[k]+SPEED, saturating at YMAX.
REQ-019 When both or neither of i_up[k]/i_down[k] are asserted, or when i_frame_tick=0, y[k] SHALL hold.
REQ-020 Saturation arithmetic SHALL be computed at 11 bits so no wrap-around is possible.
REQ-021 The new y[k] SHALL be visible on o_paddle_y on the cycle after the tick.
REQ-022 Paddle column SHALL be X[k] = PADDLE_MARGIN + k*(SCREEN_WIDTH-2*PADDLE_MARGIN-PADDLE_WIDTH)/(NUM_PADDLES-1), with X[0] = PADDLE_MARGIN when NUM_PADDLES=1.
REQ-023 With defaults, X[0]=30 and X[1]=600, giving symmetric edges.
REQ-024 hit[k] SHALL be true when X[k] <= i_pixel_x < X[k]+PADDLE_WIDTH and y[k] <= i_pixel_y < y[k]+PADDLE_HEIGHT (inclusive top edge) and i_visible=1.
REQ-025 o_hit and o_r/o_g/o_b SHALL have exactly 1 cycle of latency from the pixel inputs.
REQ-026 Colour: paddle 0 SHALL be white, paddle 1 cyan (o_r=0), paddle 2 yellow (o_b=0), paddle 3 magenta (o_g=0); the lowest-indexed hit paddle SHALL win; no hit SHALL give black.
REQ-027 Rendering SHALL use the y registers as held on the same cycle, so an update coincident with a pixel takes effect for the next pixel.

Reset
REQ-028 While i_rst_n=0, every y[k] SHALL be (SCREEN_HEIGHT-PADDLE_HEIGHT)/2 (215 at defaults).
REQ-029 While i_rst_n=0, o_hit, o_r, o_g and o_b SHALL be 0, and any acceleration state SHALL be cleared.
REQ-030 Reset asserted mid-frame SHALL take effect immediately; the first tick after release SHALL move from the centred position.

Configuration
REQ-031 With PADDLE_CTRL_ACCEL_EN defined, each paddle SHALL keep a 3-bit saturating hold counter that increments on each tick where the direction is the same as on the previous tick, and is cleared on a direction change or idle.
REQ-032 With PADDLE_CTRL_ACCEL_EN defined, once the counter reaches 7 the step SHALL be 2*SPEED, still saturating.
REQ-033 Without PADDLE_CTRL_ACCEL_EN, the step SHALL always be SPEED and no counter SHALL exist.

Structure
REQ-034 Package paddle_pkg SHALL hold the screen constants, the default geometry, the colour table and the direction encoding (IDLE/UP/DOWN).
REQ-035 Sub-module paddle_axis SHALL implement one paddle's y register, its saturation logic and its acceleration counter, and SHALL be instantiated NUM_PADDLES times by a generate loop.

Verification
REQ-036 Reset release, no input -> o_paddle_y = {215,215}; all outputs 0.
REQ-037 i_up[0] held for 60 ticks -> y[0] reaches 0 after tick 54 and stays 0; y[1]=215.
REQ-038 i_down[1] held for 70 ticks -> y[1] saturates at 430; both inputs held together -> no change.
REQ-039 y[0]=215; pixel (30,215) -> o_hit=01 and white one cycle later; pixels (29,215), (40,215) and (30,265) -> black; pixel (600,215) -> o_hit=10, cyan.
REQ-040 With PADDLE_CTRL_ACCEL_EN, i_down[0] held from 0: steps are 4 for 7 ticks, then 8 from tick 8 onward; reversing direction returns the step to 4.
REQ-041 Reset asserted between ticks after movement -> y returns to 215 asynchronously, without waiting for a clock edge.
